// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module : uart_rx
// Serial byte receiver: two-flop synchronizer, mid-bit sampling FSM and a
// one-byte valid/ready holding register with framing/overrun error pulses.
// Rev    : 1.0
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uartrx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int               c_cnt_w     = $clog2(CLKS_PER_BIT);
    localparam int               c_half      = CLKS_PER_BIT / 2;
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic [7:0]           w_shift_in;

    // The first bit received must end up in bit 7 (MSB-first) or bit 0.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_in = {shift_q[6:0], s2_q};
        end else begin : g_lsb_first
            assign w_shift_in = {s2_q, shift_q[7:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            s1_q          <= 1'b1;
            s2_q          <= 1'b1;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        s1_d          = uartrx;
        s2_d          = s1_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_d        = data_q;
        valid_d       = valid_q;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!s2_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == c_half_last) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = s2_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == c_bit_last) begin
                    shift_d = w_shift_in;
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d = '0;
                    if (s2_q) begin
                        state_d = S_IDLE;
                        // A same-cycle accept frees the register, so the load wins.
                        if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_err_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (s2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign rx_busy     = (state_q != S_IDLE);
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx: one line feeds an MSB-first and an LSB-first receiver; a frame-timing
// model predicts every output each cycle, and directed scenarios pin literal values.
module tb_uart_rx;

    localparam int CPB       = 8;
    localparam int HALF      = CPB / 2;
    localparam int LOAD_EDGE = 3 + HALF + 9 * CPB;
    localparam int MD_IDLE   = 0;
    localparam int MD_RX     = 1;
    localparam int MD_BRK    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uartrx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l, busy_m, busy_l, fe_m, fe_l, oe_m, oe_l;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .uartrx(uartrx), .rx_ready(rx_ready),
        .rx_data(data_m), .rx_valid(valid_m), .rx_busy(busy_m),
        .frame_err(fe_m), .overrun_err(oe_m)
    );

    uart_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .uartrx(uartrx), .rx_ready(rx_ready),
        .rx_data(data_l), .rx_valid(valid_l), .rx_busy(busy_l),
        .frame_err(fe_l), .overrun_err(oe_l)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         cmp_en = 1'b0;
    bit         done = 1'b0;
    bit         rand_ready = 1'b0;

    // Model state: line as seen two edges late, frame progress measured in edges.
    int         m_mode = MD_IDLE;
    int         m_t0 = 0;
    int         m_k = 0;
    logic       m_d1 = 1'b1, m_d2 = 1'b1, m_seen = 1'b1;
    logic [7:0] m_bits = 8'h00;
    logic [7:0] m_dm = 8'h00, m_dl = 8'h00;
    logic       m_valid = 1'b0, m_fe = 1'b0, m_oe = 1'b0;

    int         fe_cnt = 0, oe_cnt = 0, busy_cnt = 0, vhi_cnt = 0, vrise = 0;
    logic       v_prev = 1'b0;
    int         fall_cyc = 0;
    int         lat, fe0, oe0, vh0, b0;
    int         r;
    logic [7:0] rb;

    always @(posedge clk) begin
        // Previous-cycle DUT outputs, read before this edge updates them.
        fe_cnt   = fe_cnt + int'(fe_m);
        oe_cnt   = oe_cnt + int'(oe_m);
        busy_cnt = busy_cnt + int'(busy_m);
        vhi_cnt  = vhi_cnt + int'(valid_m);
        if (valid_m === 1'b1 && v_prev !== 1'b1) vrise = cyc;
        v_prev = valid_m;
        cyc = cyc + 1;

        m_fe = 1'b0;
        m_oe = 1'b0;
        if (!rst_n) begin
            m_d1 = 1'b1; m_d2 = 1'b1; m_mode = MD_IDLE;
            m_valid = 1'b0; m_dm = 8'h00; m_dl = 8'h00;
        end else begin
            m_seen = m_d2;
            m_d2   = m_d1;
            m_d1   = uartrx;
            if (m_valid && rx_ready) m_valid = 1'b0;
            m_k = cyc - m_t0;
            case (m_mode)
                MD_IDLE: if (!m_seen) begin m_mode = MD_RX; m_t0 = cyc; end
                MD_RX: begin
                    if (m_k == HALF && m_seen) m_mode = MD_IDLE;
                    for (int j = 0; j < 8; j++)
                        if (m_k == HALF + (j + 1) * CPB) m_bits[j] = m_seen;
                    if (m_k == HALF + 9 * CPB) begin
                        if (m_seen) begin
                            m_mode = MD_IDLE;
                            if (!m_valid) begin
                                m_valid = 1'b1;
                                for (int j = 0; j < 8; j++) begin
                                    m_dm[7 - j] = m_bits[j];
                                    m_dl[j]     = m_bits[j];
                                end
                            end else begin
                                m_oe = 1'b1;
                            end
                        end else begin
                            m_fe   = 1'b1;
                            m_mode = MD_BRK;
                        end
                    end
                end
                default: if (m_seen) m_mode = MD_IDLE;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_ready) rx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_bit(input logic b);
        uartrx = b;
        repeat (CPB) tick();
    endtask

    task automatic idle_cycles(input int n);
        uartrx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input bit msb, input bit stop_ok);
        fall_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(msb ? d[7 - i] : d[i]);
        send_bit(stop_ok);
    endtask

    initial begin
        fork
            begin : compare
                while (!done) begin
                    @(negedge clk);
                    if (cmp_en && !done) begin
                        chk("valid_m", valid_m, m_valid);
                        chk("valid_l", valid_l, m_valid);
                        chk("data_m", data_m, m_dm);
                        chk("data_l", data_l, m_dl);
                        chk("busy_m", busy_m, m_mode != MD_IDLE);
                        chk("busy_l", busy_l, m_mode != MD_IDLE);
                        chk("frame_err_m", fe_m, m_fe);
                        chk("frame_err_l", fe_l, m_fe);
                        chk("overrun_m", oe_m, m_oe);
                        chk("overrun_l", oe_l, m_oe);
                    end
                end
            end
            begin : stimulus
                @(negedge clk);
                chk("reset_data", data_m, 8'h00);
                chk("reset_valid", valid_m, 1'b0);
                chk("reset_busy", busy_m, 1'b0);
                cmp_en = 1'b1;
                tick();
                rst_n = 1'b1;
                idle_cycles(5);

                // Single byte with latency and pulse width.
                rx_ready = 1'b1;
                fe0 = fe_cnt; oe0 = oe_cnt; vh0 = vhi_cnt;
                send_frame(8'hA5, 1'b1, 1'b1);
                idle_cycles(4);
                lat = vrise - fall_cyc;
                chk("a5_data", data_m, 8'hA5);
                chk("a5_latency_within_79pm1", (lat >= 78 && lat <= 80), 1'b1);
                chk("a5_valid_width", vhi_cnt - vh0, 1);
                chk("a5_no_errors", (fe_cnt - fe0) + (oe_cnt - oe0), 0);

                // Glitch rejection.
                b0 = busy_cnt; vh0 = vhi_cnt; fe0 = fe_cnt;
                uartrx = 1'b0;
                tick(); tick();
                idle_cycles(20);
                chk("glitch_busy_seen", busy_cnt != b0, 1'b1);
                chk("glitch_no_valid", vhi_cnt - vh0, 0);
                chk("glitch_no_frame_err", fe_cnt - fe0, 0);
                chk("glitch_back_idle", busy_m, 1'b0);

                // Framing error, held break, then recovery.
                fe0 = fe_cnt; vh0 = vhi_cnt;
                send_frame(8'h3C, 1'b1, 1'b0);
                uartrx = 1'b0;
                repeat (40) tick();
                uartrx = 1'b1;
                tick(); tick();
                chk("break_busy_2_after", busy_m, 1'b1);
                tick();
                chk("break_busy_3_after", busy_m, 1'b0);
                chk("fe_pulses", fe_cnt - fe0, 1);
                chk("fe_no_valid", vhi_cnt - vh0, 0);
                idle_cycles(10);
                send_frame(8'h81, 1'b1, 1'b1);
                idle_cycles(4);
                chk("after_break_data", data_m, 8'h81);

                // Overrun.
                rx_ready = 1'b0;
                oe0 = oe_cnt;
                send_frame(8'h11, 1'b1, 1'b1);
                send_frame(8'h22, 1'b1, 1'b1);
                idle_cycles(4);
                chk("overrun_data_kept", data_m, 8'h11);
                chk("overrun_valid", valid_m, 1'b1);
                chk("overrun_pulses", oe_cnt - oe0, 1);
                rx_ready = 1'b1;
                tick();
                chk("overrun_drain", valid_m, 1'b0);

                // Load and accept in the same cycle.
                rx_ready = 1'b0;
                oe0 = oe_cnt;
                send_frame(8'h11, 1'b1, 1'b1);
                fork
                    send_frame(8'h22, 1'b1, 1'b1);
                    begin
                        repeat (LOAD_EDGE - 1) @(negedge clk);
                        rx_ready = 1'b1;
                        @(negedge clk);
                        rx_ready = 1'b0;
                    end
                join
                idle_cycles(4);
                chk("simul_data", data_m, 8'h22);
                chk("simul_valid", valid_m, 1'b1);
                chk("simul_no_overrun", oe_cnt - oe0, 0);

                // Reset during data bit 4, then an LSB-first byte.
                rx_ready = 1'b1;
                fork
                    send_frame(8'h5A, 1'b1, 1'b1);
                    begin
                        repeat (5 * CPB + 3) @(negedge clk);
                        rst_n = 1'b0;
                        @(negedge clk);
                        chk("midrst_data", data_m, 8'h00);
                        chk("midrst_valid", valid_m, 1'b0);
                        chk("midrst_busy", busy_m, 1'b0);
                        chk("midrst_errs", {fe_m, oe_m}, 2'b00);
                        rst_n = 1'b1;
                    end
                join
                idle_cycles(12 * CPB);
                send_frame(8'h01, 1'b0, 1'b1);
                idle_cycles(4);
                chk("lsb_first_data", data_l, 8'h01);
                chk("lsb_frame_on_msb_rx", data_m, 8'h80);

                // Randomized traffic.
                rand_ready = 1'b1;
                for (int n = 0; n < 50; n++) begin
                    r  = $urandom_range(0, 9);
                    rb = 8'($urandom);
                    if (r == 0) begin
                        uartrx = 1'b0;
                        repeat ($urandom_range(1, 3)) tick();
                        idle_cycles(10);
                    end else begin
                        send_frame(rb, $urandom_range(0, 1) == 1, r != 1);
                        if (r == 1) begin
                            uartrx = 1'b0;
                            repeat ($urandom_range(0, 20)) tick();
                        end
                        idle_cycles($urandom_range(0, CPB));
                    end
                end
                rand_ready = 1'b0;
                rx_ready = 1'b1;
                idle_cycles(200);
                done = 1'b1;
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver that consumes the line driven by the team's UART transmitter (`uarttx`) and turns each frame back into a parallel byte. It sits directly downstream of the transmitter, in front of any byte sink. It has these parts:
- a two-flop input synchronizer;
- a mid-bit sampling state machine;
- a one-byte holding register with a valid/ready handshake.

It reports framing and overrun errors as one-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 16, clock cycles per serial bit. Legal range is 4 or more.
- `MSB_FIRST`, default 1. When 1, the first data bit received is `rx_data[7]`, which matches the team's transmitter. When 0, the first bit is `rx_data[0]`.
- `clk` in 1: the only clock. All logic is rising-edge.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `uartrx` in 1: serial line, asynchronous to `clk`. It idles high.
- `rx_ready` in 1: the sink accepts the held byte in any cycle where `rx_valid && rx_ready`.
- `rx_data` out 8: the held byte. It is stable while `rx_valid` is high.
- `rx_valid` out 1: the holding register is full.
- `rx_busy` out 1: high in every state except IDLE.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_err` out 1: one-cycle pulse when a completed byte is dropped because the holding register is full.

## Operation
- **Synchronizer.** Two flops, `s1` and `s2`. Both reset to 1. The FSM sees only `s2`.
- **Constant.** `HALF = CLKS_PER_BIT/2`, using integer division.
- **Counters.** A bit counter of width `$clog2(CLKS_PER_BIT)` and a 3-bit data index.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
- **IDLE.**
  - When `s2==0`, go to START and clear the counter.
- **START.**
  - Count up to `HALF-1`.
  - At that count, sample `s2`:
    - If `s2==1`, it was a glitch. Go to IDLE and report no error.
    - If `s2==0`, clear the counter and index, then go to DATA.
- **DATA.**
  - At each count of `CLKS_PER_BIT-1`, sample `s2` into the shift register, then clear the counter.
  - When `MSB_FIRST=1`, shift left and insert at bit 0. When `MSB_FIRST=0`, shift right and insert at bit 7.
  - After the 8th sample, go to STOP.
- **STOP.** At count `CLKS_PER_BIT-1`, sample `s2`:
  - If `s2==1`, the frame is good. Load it into the holding register if the register is empty, or will be emptied this cycle (see the holding register rules). Otherwise pulse `overrun_err` and discard the new byte. In both cases go to IDLE.
  - If `s2==0`, pulse `frame_err`, discard the byte, and go to BREAK.
- **BREAK.**
  - Wait for `s2==1`, then go to IDLE.
  - This prevents a held-low line from being taken as repeated start bits.
- **Holding register.**
  - `rx_valid` is set when a good frame is loaded.
  - `rx_valid` is cleared on `rx_valid && rx_ready`.
  - If a load and an accept happen in the same cycle, the load wins: the new byte is taken, `rx_valid` stays 1, and there is no overrun.
- **Reset.**
  - `rst_n==0` at any point, including mid-frame, takes effect at the next rising edge:
    - FSM to IDLE and counters to 0;
    - `rx_data=8'h00`;
    - `rx_valid`, `rx_busy`, `frame_err` and `overrun_err` to 0;
    - `s1` and `s2` to 1.
  - A partial frame is lost.
  - After reset is released, a line that is already low is treated as a new start bit.

## Timing
- Take edge 0 as the first rising edge at which `uartrx` is sampled low. Then:
  - `s2` goes low after edge 1;
  - the FSM enters START at edge 2;
  - `rx_busy` is high from edge 2.
- Start-bit sample: `HALF` cycles after entering START.
- Data bit k (k=0..7): sampled `HALF + (k+1)*CLKS_PER_BIT` cycles after entering START.
- Stop-bit sample: `HALF + 9*CLKS_PER_BIT` cycles after entering START.
- At the edge after the stop-bit sample:
  - `rx_valid`, `rx_data`, `frame_err` and `overrun_err` update;
  - `rx_busy` falls, or, on a framing error, stays high through BREAK.
- Latency from the line falling to `rx_valid`: `3 + HALF + 9*CLKS_PER_BIT` cycles, ±1 for the asynchronous edge.
- Back-to-back frames: the FSM is in IDLE about half a bit after the stop sample, so a start bit immediately following the stop bit is caught.

## Test plan
- **Single byte.** `CLKS_PER_BIT=8`, `MSB_FIRST=1`, `rx_ready=1`. Send 0xA5 MSB-first with a good stop bit. Required: `rx_data=8'hA5`, `rx_valid` high for exactly 1 cycle, at 3+4+72 cycles ±1 after the line falls. No error pulses.
- **Glitch rejection.** Drive `uartrx` low for 2 cycles, then high. Required: `rx_busy` pulses, the FSM returns to IDLE, `rx_valid` stays 0, and there is no `frame_err`.
- **Framing error.** Send 0x3C with the stop bit low, then hold the line low for 40 cycles, then release it. Required:
  - one `frame_err` pulse;
  - `rx_valid` stays 0;
  - `rx_busy` stays high until 3 cycles after release;
  - a following good 0x81 is received correctly.
- **Overrun.** `rx_ready=0`. Send 0x11 then 0x22 back-to-back. Required: `rx_data` stays 0x11 and one `overrun_err` pulse at the end of the second frame. Then raise `rx_ready`: `rx_valid` drops the next cycle.
- **Simultaneous load and accept.** Time `rx_ready` to first go high in the same cycle that 0x22 completes. Required: `rx_data=8'h22`, `rx_valid` stays 1, no `overrun_err`.
- **Reset mid-frame and LSB-first.**
  - Assert `rst_n=0` for 1 cycle during data bit 4. Required: all outputs reach their reset values at the next edge.
  - Then set `MSB_FIRST=0` and send 0x01 LSB-first. Required: `rx_data=8'h01`.
